lmsm_mem_sequencer: RTL and testbench

- Memory-stage block directly downstream of the EX/MEM pipeline register.
- Ordinary instructions: passes the EX/MEM memory request straight to data memory, with no added latency.
- LM/SM instructions: walks the 8-bit register mask, makes one data-memory access per selected register at consecutive addresses, and stalls upstream stages until the last transfer.
- LM load results go out on a registered writeback port toward the MEM/WB register.

---
 rtl/lmsm_mem_sequencer.sv | 141 ++++++++++++++
 tb/tb_lmsm_mem_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_mem_sequencer.sv
// lmsm_mem_sequencer: memory stage sitting right after the EX/MEM register.
// Ordinary instructions pass straight through to data memory. Load-multiple
// and store-multiple walk the register mask and make one access per selected
// register at consecutive addresses. Upstream stages are stalled until the
// last transfer. Loaded words return on a registered writeback port.
module lmsm_mem_sequencer #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111,
    parameter int         AW        = 16,
    parameter int         DW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   IR,
    input  logic [AW-1:0] ALUOut,
    input  logic          WriteMem,
    input  logic [DW-1:0] StoreData,
    output logic [2:0]    rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          wb_en,
    output logic [2:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          busy
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        r_state;
    logic          r_isStore;
    logic [AW-1:0] r_base;
    logic [7:0]    r_rem;
    logic [3:0]    r_count;

    logic [3:0]    w_opcode;
    logic [7:0]    w_mask;
    logic          w_isMulti;
    logic          w_capture;
    logic [2:0]    w_idx;
    logic [7:0]    w_nextRem;
    logic          w_last;
    logic [AW-1:0] w_runAddr;
    logic          w_stallRaw;
    logic          w_weRaw;
    logic          w_unused;

    assign w_opcode  = IR[15:12];
    assign w_mask    = IR[7:0];
    assign w_isMulti = (w_opcode == LM_OPCODE) || (w_opcode == SM_OPCODE);
    assign w_capture = (r_state == S_IDLE) && w_isMulti && (w_mask != 8'd0);
    assign w_nextRem = r_rem & (r_rem - 8'd1);
    assign w_last    = (w_nextRem == 8'd0);
    assign w_runAddr = r_base + AW'(r_count);
    assign w_unused  = ^IR[11:8];

    // Find the lowest-numbered register still pending in the mask.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_rem[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Steer the memory port: pass-through in IDLE, sequenced access in RUN.
    always_comb begin
        mem_addr   = ALUOut;
        mem_wdata  = StoreData;
        w_weRaw    = WriteMem;
        w_stallRaw = 1'b0;
        rf_rd_addr = 3'd0;
        if (r_state == S_RUN) begin
            mem_addr   = w_runAddr;
            mem_wdata  = {DW{1'b0}};
            w_weRaw    = 1'b0;
            w_stallRaw = !w_last;
            if (r_isStore) begin
                rf_rd_addr = w_idx;
                mem_wdata  = rf_rd_data;
                w_weRaw    = 1'b1;
            end
        end else if (w_capture) begin
            w_weRaw    = 1'b0;
            w_stallRaw = 1'b1;
        end
    end

    // Reset forces stall and write-enable low at once, even mid-sequence.
    assign stall  = reset & w_stallRaw;
    assign mem_we = reset & w_weRaw;
    assign busy   = (r_state == S_RUN);

    // Sequencer state and the registered load writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_isStore <= 1'b0;
            r_base    <= {AW{1'b0}};
            r_rem     <= 8'd0;
            r_count   <= 4'd0;
            wb_en     <= 1'b0;
            wb_addr   <= 3'd0;
            wb_data   <= {DW{1'b0}};
        end else begin
            wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_isStore <= (w_opcode == SM_OPCODE);
                        r_base    <= ALUOut;
                        r_rem     <= w_mask;
                        r_count   <= 4'd0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem   <= w_nextRem;
                    r_count <= r_count + 4'd1;
                    if (!r_isStore) begin
                        wb_en   <= 1'b1;
                        wb_addr <= w_idx;
                        wb_data <= mem_rdata;
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
// tb_lmsm_mem_sequencer: randomized bench for the LM/SM memory sequencer with
// a simple memory and register file around the design. Expected transfers
// are derived from the mask as an ordered list of registers and addresses.
module tb_lmsm_mem_sequencer;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;
    localparam logic [3:0] OP_SW = 4'b0101;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IR;
    logic [15:0] ALUOut;
    logic        WriteMem;
    logic [15:0] StoreData;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;

    logic [15:0] memArr [0:65535];
    logic [15:0] rfArr  [0:7];
    int          writeCount = 0;
    int          vectors = 0;
    int          miscompares = 0;

    lmsm_mem_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .ALUOut     (ALUOut),
        .WriteMem   (WriteMem),
        .StoreData  (StoreData),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Combinational reads from the memory and register file.
    assign mem_rdata  = memArr[mem_addr];
    assign rf_rd_data = rfArr[rf_rd_addr];

    // Memory captures writes on the rising edge and counts them.
    always @(posedge clk) begin
        if (mem_we) begin
            memArr[mem_addr] <= mem_wdata;
            writeCount <= writeCount + 1;
        end
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setNop();
        IR        = 16'h0000;
        ALUOut    = 16'($urandom);
        WriteMem  = 1'b0;
        StoreData = 16'($urandom);
    endtask

    task automatic storeWord(input logic [15:0] addr, input logic [15:0] data);
        IR        = {OP_SW, 12'($urandom)};
        ALUOut    = addr;
        WriteMem  = 1'b1;
        StoreData = data;
        nextCycle();
        setNop();
    endtask

    task automatic maskToRegs(input logic [7:0] mask, output logic [2:0] regs [$]);
        regs = {};
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) regs.push_back(3'(i));
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        IR        = {OP_SM, 4'h0, 8'hFF};
        ALUOut    = 16'h1234;
        WriteMem  = 1'b1;
        StoreData = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_en: got %b want 0", wb_en); end
        vectors++; if (wb_addr !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_wb_addr: got %0d want 0", wb_addr); end
        vectors++; if (wb_data !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_wb_data: got %h want 0", wb_data); end
        setNop();
        reset = 1'b1;
        nextCycle();
    endtask

    task automatic test_passthrough(input int iterations);
        logic [3:0] opc;
        for (int it = 0; it < iterations; it++) begin
            if (it == 0) begin
                IR        = {OP_SW, 12'h000};
                ALUOut    = 16'h0040;
                WriteMem  = 1'b1;
                StoreData = 16'hBEEF;
            end else begin
                do opc = 4'($urandom); while (opc == OP_LM || opc == OP_SM);
                IR        = {opc, 12'($urandom)};
                ALUOut    = 16'($urandom);
                WriteMem  = 1'($urandom);
                StoreData = 16'($urandom);
            end
            @(negedge clk);
            vectors++; if (mem_addr !== ALUOut) begin miscompares++; $display("[TB] FAIL pass_addr: got %h want %h", mem_addr, ALUOut); end
            vectors++; if (mem_we !== WriteMem) begin miscompares++; $display("[TB] FAIL pass_we: got %b want %b", mem_we, WriteMem); end
            vectors++; if (mem_wdata !== StoreData) begin miscompares++; $display("[TB] FAIL pass_wdata: got %h want %h", mem_wdata, StoreData); end
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_stall: got %b want 0", stall); end
            vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_wb_en: got %b want 0", wb_en); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_busy: got %b want 0", busy); end
            nextCycle();
        end
        setNop();
    endtask

    task automatic test_lm(input logic [15:0] base, input logic [7:0] mask);
        logic [2:0]  regs [$];
        logic [15:0] vals [$];
        logic [15:0] v;
        int          n;
        maskToRegs(mask, regs);
        n = regs.size();
        vals = {};
        for (int k = 0; k < n; k++) begin
            v = 16'($urandom);
            vals.push_back(v);
            storeWord(base + 16'(k), v);
        end
        IR        = {OP_LM, 4'($urandom), mask};
        ALUOut    = base;
        WriteMem  = 1'b0;
        StoreData = 16'($urandom);
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL lm_capture_stall: got %b want 1", stall); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL lm_capture_we: got %b want 0", mem_we); end
        nextCycle();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vectors++; if (mem_addr !== 16'(base + 16'(k))) begin miscompares++; $display("[TB] FAIL lm_addr[%0d]: got %h want %h", k, mem_addr, 16'(base + 16'(k))); end
            vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL lm_we[%0d]: got %b want 0", k, mem_we); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL lm_busy[%0d]: got %b want 1", k, busy); end
            vectors++; if (stall !== (k != n - 1)) begin miscompares++; $display("[TB] FAIL lm_stall[%0d]: got %b want %b", k, stall, (k != n - 1)); end
            vectors++; if (wb_en !== (k > 0)) begin miscompares++; $display("[TB] FAIL lm_wb_en[%0d]: got %b want %b", k, wb_en, (k > 0)); end
            if (k > 0) begin
                vectors++; if (wb_addr !== regs[k-1]) begin miscompares++; $display("[TB] FAIL lm_wb_addr[%0d]: got %0d want %0d", k, wb_addr, regs[k-1]); end
                vectors++; if (wb_data !== vals[k-1]) begin miscompares++; $display("[TB] FAIL lm_wb_data[%0d]: got %h want %h", k, wb_data, vals[k-1]); end
            end
            nextCycle();
            if (k == n - 1) setNop();
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL lm_end_busy: got %b want 0", busy); end
        vectors++; if (wb_en !== 1'b1) begin miscompares++; $display("[TB] FAIL lm_end_wb_en: got %b want 1", wb_en); end
        vectors++; if (wb_addr !== regs[n-1]) begin miscompares++; $display("[TB] FAIL lm_end_wb_addr: got %0d want %0d", wb_addr, regs[n-1]); end
        vectors++; if (wb_data !== vals[n-1]) begin miscompares++; $display("[TB] FAIL lm_end_wb_data: got %h want %h", wb_data, vals[n-1]); end
        nextCycle();
        @(negedge clk);
        vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL lm_after_wb_en: got %b want 0", wb_en); end
        nextCycle();
    endtask

    task automatic test_sm(input logic [15:0] base, input logic [7:0] mask, input bit randomRf);
        logic [2:0] regs [$];
        int         n;
        int         w0;
        maskToRegs(mask, regs);
        n = regs.size();
        if (randomRf) begin
            for (int i = 0; i < 8; i++) rfArr[i] = 16'($urandom);
        end
        w0 = writeCount;
        IR        = {OP_SM, 4'($urandom), mask};
        ALUOut    = base;
        WriteMem  = 1'b1;
        StoreData = 16'($urandom);
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL sm_capture_stall: got %b want 1", stall); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL sm_capture_we: got %b want 0", mem_we); end
        nextCycle();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL sm_we[%0d]: got %b want 1", k, mem_we); end
            vectors++; if (mem_addr !== 16'(base + 16'(k))) begin miscompares++; $display("[TB] FAIL sm_addr[%0d]: got %h want %h", k, mem_addr, 16'(base + 16'(k))); end
            vectors++; if (rf_rd_addr !== regs[k]) begin miscompares++; $display("[TB] FAIL sm_rf_addr[%0d]: got %0d want %0d", k, rf_rd_addr, regs[k]); end
            vectors++; if (mem_wdata !== rfArr[regs[k]]) begin miscompares++; $display("[TB] FAIL sm_wdata[%0d]: got %h want %h", k, mem_wdata, rfArr[regs[k]]); end
            vectors++; if (stall !== (k != n - 1)) begin miscompares++; $display("[TB] FAIL sm_stall[%0d]: got %b want %b", k, stall, (k != n - 1)); end
            vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL sm_wb_en[%0d]: got %b want 0", k, wb_en); end
            nextCycle();
            if (k == n - 1) setNop();
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sm_end_busy: got %b want 0", busy); end
        vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL sm_end_wb_en: got %b want 0", wb_en); end
        vectors++; if (writeCount - w0 !== n) begin miscompares++; $display("[TB] FAIL sm_write_count: got %0d want %0d", writeCount - w0, n); end
        for (int k = 0; k < n; k++) begin
            vectors++; if (memArr[16'(base + 16'(k))] !== rfArr[regs[k]]) begin miscompares++; $display("[TB] FAIL sm_mem[%0d]: got %h want %h", k, memArr[16'(base + 16'(k))], rfArr[regs[k]]); end
        end
        nextCycle();
    endtask

    task automatic test_zero_mask();
        for (int j = 0; j < 2; j++) begin
            IR        = {(j == 0) ? OP_LM : OP_SM, 4'($urandom), 8'h00};
            ALUOut    = 16'($urandom);
            WriteMem  = (j == 1);
            StoreData = 16'($urandom);
            @(negedge clk);
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_stall[%0d]: got %b want 0", j, stall); end
            vectors++; if (mem_we !== WriteMem) begin miscompares++; $display("[TB] FAIL zero_we[%0d]: got %b want %b", j, mem_we, WriteMem); end
            vectors++; if (mem_addr !== ALUOut) begin miscompares++; $display("[TB] FAIL zero_addr[%0d]: got %h want %h", j, mem_addr, ALUOut); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy[%0d]: got %b want 0", j, busy); end
            nextCycle();
            setNop();
            @(negedge clk);
            vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_wb_en[%0d]: got %b want 0", j, wb_en); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy_after[%0d]: got %b want 0", j, busy); end
            nextCycle();
        end
    endtask

    task automatic test_reset_mid_sm();
        int w0;
        for (int i = 0; i < 8; i++) rfArr[i] = 16'($urandom);
        w0 = writeCount;
        IR        = {OP_SM, 4'h0, 8'hFF};
        ALUOut    = 16'($urandom);
        WriteMem  = 1'b1;
        StoreData = 16'($urandom);
        nextCycle();
        nextCycle();
        nextCycle();
        nextCycle();
        #2;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_stall: got %b want 1", stall); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_we: got %b want 1", mem_we); end
        reset = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_stall: got %b want 0", stall); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_we: got %b want 0", mem_we); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_busy: got %b want 0", busy); end
        setNop();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_busy: got %b want 0", busy); end
        vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_wb_en: got %b want 0", wb_en); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_stall: got %b want 0", stall); end
        vectors++; if (writeCount - w0 !== 3) begin miscompares++; $display("[TB] FAIL mid_write_count: got %0d want 3", writeCount - w0); end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        logic [15:0] v;
        logic [15:0] swAddr;
        logic [15:0] swData;
        base   = 16'h2000 + 16'($urandom_range(0, 255));
        v      = 16'($urandom);
        swAddr = 16'h3000 + 16'($urandom_range(0, 255));
        swData = 16'($urandom);
        storeWord(base, v);
        IR        = {OP_LM, 4'h0, 8'h01};
        ALUOut    = base;
        WriteMem  = 1'b0;
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_capture_stall: got %b want 1", stall); end
        nextCycle();
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_run_stall: got %b want 0", stall); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_run_busy: got %b want 1", busy); end
        vectors++; if (mem_addr !== base) begin miscompares++; $display("[TB] FAIL b2b_run_addr: got %h want %h", mem_addr, base); end
        nextCycle();
        IR        = {OP_SW, 12'($urandom)};
        ALUOut    = swAddr;
        WriteMem  = 1'b1;
        StoreData = swData;
        @(negedge clk);
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_sw_we: got %b want 1", mem_we); end
        vectors++; if (mem_addr !== swAddr) begin miscompares++; $display("[TB] FAIL b2b_sw_addr: got %h want %h", mem_addr, swAddr); end
        vectors++; if (mem_wdata !== swData) begin miscompares++; $display("[TB] FAIL b2b_sw_wdata: got %h want %h", mem_wdata, swData); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_sw_stall: got %b want 0", stall); end
        vectors++; if (wb_en !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_wb_en: got %b want 1", wb_en); end
        vectors++; if (wb_addr !== 3'd0) begin miscompares++; $display("[TB] FAIL b2b_wb_addr: got %0d want 0", wb_addr); end
        vectors++; if (wb_data !== v) begin miscompares++; $display("[TB] FAIL b2b_wb_data: got %h want %h", wb_data, v); end
        nextCycle();
        setNop();
        @(negedge clk);
        vectors++; if (memArr[swAddr] !== swData) begin miscompares++; $display("[TB] FAIL b2b_mem: got %h want %h", memArr[swAddr], swData); end
        vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_after_wb_en: got %b want 0", wb_en); end
        nextCycle();
    endtask

    task automatic test_random_multi(input int iterations);
        logic [15:0] base;
        logic [7:0]  mask;
        for (int it = 0; it < iterations; it++) begin
            base = ($urandom_range(0, 1) == 1) ? 16'hFFF9 + 16'($urandom_range(0, 6)) : 16'($urandom);
            do mask = 8'($urandom); while (mask == 8'h00);
            if ($urandom_range(0, 1) == 1) test_lm(base, mask);
            else test_sm(base, mask, 1'b1);
        end
    endtask

    // Run the scenarios in order and report the totals.
    initial begin
        for (int i = 0; i < 8; i++) rfArr[i] = 16'h0000;
        test_reset();
        test_passthrough(8);
        test_lm(16'h0100, 8'b1000_0101);
        rfArr[0] = 16'd5;
        rfArr[1] = 16'd9;
        test_sm(16'hFFFF, 8'b0000_0011, 1'b0);
        test_zero_mask();
        test_reset_mid_sm();
        test_back_to_back();
        test_lm(16'hFFFE, 8'hFF);
        test_random_multi(10);
        test_passthrough(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
